// File: rtl/chrom_serial_loader.sv
// Chromosome serial loader: frames a byte stream (SYNC, payload, XOR checksum),
// assembles the chromosome in a shadow register and commits it atomically.
module chrom_serial_loader #(
    parameter int unsigned             CHROM_BITS  = 33,
    parameter logic [7:0]              SYNC_BYTE   = 8'hA5,
    parameter int unsigned             TIMEOUT_CYC = 1_000_000,
    parameter logic [CHROM_BITS-1:0]   CHROM_RESET = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [CHROM_BITS-1:0] chrom_out,
    output logic                  chrom_load,
    output logic                  err_csum,
    output logic                  err_timeout,
    output logic [7:0]            frame_count
);

    localparam int unsigned NBYTES   = (CHROM_BITS + 7) / 8;
    localparam int unsigned SHADOW_W = NBYTES * 8;
    localparam int unsigned IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2,
        S_COMMIT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              csum_q, csum_d;
    logic [SHADOW_W-1:0]     shadow_q, shadow_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [CHROM_BITS-1:0]   chrom_d;
    logic                    load_d, ecs_d, eto_d, ready_d;
    logic [7:0]              fcnt_d;
    logic                    accept;

    assign accept = in_valid & in_ready;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            csum_q      <= '0;
            shadow_q    <= '0;
            tmo_q       <= '0;
            chrom_out   <= CHROM_RESET;
            chrom_load  <= 1'b0;
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
            frame_count <= '0;
            in_ready    <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            shadow_q    <= shadow_d;
            tmo_q       <= tmo_d;
            chrom_out   <= chrom_d;
            chrom_load  <= load_d;
            err_csum    <= ecs_d;
            err_timeout <= eto_d;
            frame_count <= fcnt_d;
            in_ready    <= ready_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        shadow_d = shadow_q;
        tmo_d    = tmo_q;
        chrom_d  = chrom_out;
        load_d   = 1'b0;
        ecs_d    = 1'b0;
        eto_d    = 1'b0;
        fcnt_d   = frame_count;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = S_PAYLOAD;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    shadow_d[{idx_q, 3'b000} +: 8] = in_data;
                    csum_d = csum_q ^ in_data;
                    tmo_d  = '0;
                    if (idx_q == IDX_W'(NBYTES - 1)) begin
                        state_d = S_CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d  = S_IDLE;
                    eto_d    = 1'b1;
                    shadow_d = '0;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_CHECK: begin
                if (accept) begin
                    tmo_d = '0;
                    if (in_data == csum_q) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_IDLE;
                        ecs_d   = 1'b1;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d  = S_IDLE;
                    eto_d    = 1'b1;
                    shadow_d = '0;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_COMMIT: begin
                chrom_d = shadow_q[CHROM_BITS-1:0];
                load_d  = 1'b1;
                fcnt_d  = frame_count + 8'd1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Byte input is blocked only while the commit cycle is in progress
        ready_d = (state_d != S_COMMIT);
    end

endmodule

// File: tb/tb_chrom_serial_loader.sv
// Directed testbench for chrom_serial_loader (CHROM_BITS=33, short timeout).
module tb_chrom_serial_loader;

    localparam int unsigned CB  = 33;
    localparam int unsigned TMO = 16;

    logic          clk;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [CB-1:0] chrom_out;
    logic          chrom_load;
    logic          err_csum;
    logic          err_timeout;
    logic [7:0]    frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    chrom_serial_loader #(
        .CHROM_BITS (CB),
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT_CYC(TMO),
        .CHROM_RESET('0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .chrom_out  (chrom_out),
        .chrom_load (chrom_load),
        .err_csum   (err_csum),
        .err_timeout(err_timeout),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the hand-computed expectation
    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte at a negedge and hold it until accepted (bounded)
    task automatic send(input logic [7:0] b);
        logic rdy;
        logic ok;
        ok       = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rdy = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("send_bound", 40'(ok), 40'd1);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, cs);
        send(8'hA5); send(b0); send(b1); send(b2); send(b3); send(b4); send(cs);
    endtask

    // Sample the one-cycle commit pulse after the checksum handshake
    task automatic expect_commit(input string tag, input logic [CB-1:0] chrom, input logic [7:0] fc);
        check({tag, "_ready_low"}, 40'(in_ready), 40'd0);
        @(negedge clk);
        check({tag, "_load"}, 40'(chrom_load), 40'd1);
        check({tag, "_chrom"}, 40'(chrom_out), 40'(chrom));
        check({tag, "_fc"}, 40'(frame_count), 40'(fc));
        @(negedge clk);
        check({tag, "_load_end"}, 40'(chrom_load), 40'd0);
    endtask

    initial begin
        int k;
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 40'(in_ready), 40'd1);
        check("rst_chrom", 40'(chrom_out), 40'd0);
        check("rst_load", 40'(chrom_load), 40'd0);
        check("rst_ecs", 40'(err_csum), 40'd0);
        check("rst_eto", 40'(err_timeout), 40'd0);
        check("rst_fc", 40'(frame_count), 40'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: low byte FF
        send_frame(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        expect_commit("f1", 33'h0_0000_00FF, 8'd1);

        // Top byte FF: only bit 32 survives, checksum covers dropped bits
        send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF);
        expect_commit("f2", 33'h1_0000_0000, 8'd2);

        // Bad checksum (correct would be 45)
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h00);
        check("csum_pulse", 40'(err_csum), 40'd1);
        check("csum_no_load", 40'(chrom_load), 40'd0);
        @(negedge clk);
        check("csum_pulse_end", 40'(err_csum), 40'd0);
        check("csum_chrom_keep", 40'(chrom_out), 40'h1_0000_0000);
        check("csum_fc_keep", 40'(frame_count), 40'd2);

        // Inter-byte timeout after two payload bytes
        send(8'hA5); send(8'h11); send(8'h22);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (err_timeout) begin
                k = i;
                break;
            end
        end
        check("tmo_cycles", 40'(k), 40'(TMO));
        check("tmo_ready", 40'(in_ready), 40'd1);
        @(negedge clk);
        check("tmo_pulse_end", 40'(err_timeout), 40'd0);
        check("tmo_chrom_keep", 40'(chrom_out), 40'h1_0000_0000);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h04);
        expect_commit("f_after_tmo", 33'h0_0403_0201, 8'd3);

        // Leading garbage skipped; SYNC value inside payload is data
        send(8'h3C); send(8'h00);
        check("garbage_ecs", 40'(err_csum), 40'd0);
        check("garbage_eto", 40'(err_timeout), 40'd0);
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h01);
        check("garb_ready_low", 40'(in_ready), 40'd0);

        // Next SYNC held through COMMIT, accepted one cycle later
        in_data  = 8'hA5;
        in_valid = 1'b1;
        @(negedge clk);
        check("garb_load", 40'(chrom_load), 40'd1);
        check("garb_chrom", 40'(chrom_out), 40'h1_A5A5_A5A5);
        check("garb_fc", 40'(frame_count), 40'd4);
        check("b2b_ready", 40'(in_ready), 40'd1);
        @(negedge clk);
        in_valid = 1'b0;
        send(8'h10); send(8'h20); send(8'h30); send(8'h40); send(8'h00); send(8'h40);
        expect_commit("b2b", 33'h0_4030_2010, 8'd5);

        // Reset mid-frame after the third payload byte
        send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_chrom", 40'(chrom_out), 40'd0);
        check("mrst_fc", 40'(frame_count), 40'd0);
        check("mrst_ready", 40'(in_ready), 40'd1);
        check("mrst_errs", 40'({err_csum, err_timeout}), 40'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_errs_after", 40'({err_csum, err_timeout}), 40'd0);
        send_frame(8'hAA, 8'h55, 8'h00, 8'hFF, 8'h00, 8'h00);
        expect_commit("f_after_rst", 33'h0_FF00_55AA, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
